screen_scan: RTL and testbench
==============================

SCREEN_SCAN -- requirements
Module: screen_scan

Interface
REQ-001 mck  input  1  master clock; all logic on posedge mck.
REQ-002 rin  input  1  reset, synchronous, active-high.
REQ-003 pix_ce  input  1  pixel clock enable; all counters and outputs advance only on mck cycles with pix_ce=1.
REQ-004 lcdon  input  1  display enable; 0 blanks ink, timing keeps running.
REQ-005 vram_a  output  14  VRAM read address {zline[5:0], nib[7:0]}.
REQ-006 vram_di  input  4  VRAM read data, valid 1 mck after vram_a changes; bit 3 = leftmost pixel, 1 = ink.
REQ-007 hs  output  1  horizontal sync, active-low.
REQ-008 vs  output  1  vertical sync, active-low.
REQ-009 de  output  1  display enable, high in the 640x480 visible area.
REQ-010 pix  output  1  pixel, 1 = ink.

Function
REQ-011 Timing SHALL be 640x480: H total 800 (visible 0-639, front porch 640-655, sync 656-751, back porch 752-799); V total 525 (visible 0-479, front porch 480-489, sync 490-491, back porch 492-524).
REQ-012 hcnt SHALL wrap 799->0; vcnt SHALL increment on each hcnt wrap and wrap 524->0.
REQ-013 Z88 window SHALL be vcnt 112..367 (64 Z88 lines x 4 repeats), all 640 columns; zline = (vcnt-112)>>2.
REQ-014 A row SHALL hold 160 nibbles, nib 0..159; nibble n covers hcnt 4n..4n+3.
REQ-015 Address for nibble n+1 SHALL be driven at the pix_ce tick where hcnt=4n+2; nibble 0 address SHALL be driven at hcnt=798 of the preceding line.
REQ-016 vram_di SHALL be captured into a hold register at the pix_ce tick where hcnt=4n+3 (or 799), then loaded into a 4-bit shift register at hcnt=4(n+1) (or 0), shifting out MSB first.
REQ-017 No VRAM address SHALL be driven for nib > 159; vram_a SHALL hold its last value outside the window.
REQ-018 pix, de, hs and vs SHALL be registered and mutually aligned, with a fixed 1 pix_ce latency from the hcnt/vcnt they represent.
REQ-019 pix SHALL be 0 when de=0, outside the Z88 window, or when lcdon=0.
REQ-020 lcdon changes SHALL take effect on the next pix_ce tick, without resetting counters.
REQ-021 pix_ce=0 for any number of cycles SHALL freeze all state and outputs.

Reset
REQ-022 While rin=1: hcnt=0, vcnt=0, vram_a=0, shift and hold registers=0, pix=0, de=0, hs=1, vs=1.
REQ-023 rin asserted mid-line SHALL abort the line; the first pix_ce after release SHALL start pixel (0,0).

Configuration
REQ-024 Macro SCREEN_SCAN_BORDER_EN: when defined, pix SHALL be 1 on vcnt 111 and 368 (hcnt 0..639) regardless of lcdon; when undefined, those lines SHALL be blank.

Structure
REQ-025 Package scan_pkg SHALL hold all H/V timing constants, window start/height, repeat factor and nibbles-per-row.
REQ-026 Sub-module scan_timing SHALL contain hcnt/vcnt, hs/vs/de generation; screen_scan SHALL contain fetch, shift and blanking.

Verification
REQ-027 pix_ce=1 constant, reset released: hs low for exactly 96 pixels per 800; vs low for exactly 2 lines per 525.
REQ-028 VRAM model: address {6'd0,8'd0}=4'b1010, rest 0: vcnt 112..115 pix at hcnt 0..3 = 1,0,1,0; all other pixels 0.
REQ-029 VRAM addr {6'd63,8'd159}=4'hF: pix=1 at hcnt 636..639 on vcnt 364..367 only; vram_a never shows nib 160.
REQ-030 pix_ce every 4th mck, all-ink VRAM, lcdon=0 on line 200 from hcnt 320: pix 0 from hcnt 320 onward, de unchanged, counters unaffected.
REQ-031 rin pulsed at hcnt=400, vcnt=150: outputs at reset values; after release first pixel is (0,0) and vram_a restarts at nib 0 at hcnt=798.
REQ-032 SCREEN_SCAN_BORDER_EN defined, VRAM all 0: pix=1 for all 640 columns on vcnt 111 and 368; undefined: pix=0 there.

Source files
------------

// File: rtl/scan_pkg.sv
// scan_pkg: shared timing constants and helpers for the Z88-style screen scanner.
//
// Contents:
//   - 640x480 horizontal/vertical timing (visible, porches, sync, totals)
//   - Z88 window placement (first line, line count), line repeat factor
//   - VRAM row geometry (nibbles per row, address field widths)
//   - in_span(): half-open range test used for sync/window decode
package scan_pkg;

  // Counter width covers both 0..799 and 0..524.
  localparam int unsigned CntW = 10;
  typedef logic [CntW-1:0] cnt_t;

  // Horizontal timing, in pixels.
  localparam cnt_t HVisible   = 10'd640;
  localparam cnt_t HSyncStart = 10'd656;
  localparam cnt_t HSyncEnd   = 10'd752;  // exclusive
  localparam cnt_t HLast      = 10'd799;  // H total 800
  // Last fetch slot of a line addresses nibble 0 of the next line.
  localparam cnt_t HFetchWrap = 10'd798;

  // Vertical timing, in lines.
  localparam int unsigned VVisible   = 480;
  localparam int unsigned VSyncStart = 490;
  localparam int unsigned VSyncEnd   = 492;  // exclusive
  localparam int unsigned VTotal     = 525;

  // Z88 window: 64 source lines, each shown on RepeatLines display lines.
  localparam int unsigned WinStart    = 112;
  localparam int unsigned WinLines    = 256;
  localparam int unsigned RepeatLog2  = 2;
  localparam int unsigned RepeatLines = 1 << RepeatLog2;

  // VRAM geometry.
  localparam int unsigned ZLineW     = 6;
  localparam int unsigned NibW       = 8;
  localparam int unsigned AddrW      = ZLineW + NibW;
  localparam logic [NibW-1:0] NibsPerRow = 8'd160;

  // True when lo <= x < hi.
  function automatic logic in_span(input cnt_t x, input cnt_t lo, input cnt_t hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/scan_timing.sv
// scan_timing: raster counters and registered sync/enable generation.
//
// Ports:
//   clk_i     master clock
//   rst_i     synchronous active-high reset
//   pix_ce_i  pixel enable; state only moves on cycles where it is high
//   hcnt_o    current horizontal position 0..799 (unregistered view of the counter)
//   vcnt_o    current vertical position 0..TotalLines-1
//   hs_o      horizontal sync, active-low, registered
//   vs_o      vertical sync, active-low, registered
//   de_o      visible-area enable, registered
//
// hs/vs/de are registered from the counter value at a pixel tick, so they lag the
// counters by exactly one tick; the pixel path in the top uses the same latency.
// Vertical geometry is parameterised so short frames can be built; defaults are
// the 480-line mode.
module scan_timing
  import scan_pkg::*;
#(
  parameter int unsigned VisLines    = VVisible,
  parameter int unsigned SyncLineBeg = VSyncStart,
  parameter int unsigned SyncLineEnd = VSyncEnd,
  parameter int unsigned TotalLines  = VTotal
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pix_ce_i,
  output cnt_t hcnt_o,
  output cnt_t vcnt_o,
  output logic hs_o,
  output logic vs_o,
  output logic de_o
);

  localparam cnt_t VVisC  = cnt_t'(VisLines);
  localparam cnt_t VSyncB = cnt_t'(SyncLineBeg);
  localparam cnt_t VSyncE = cnt_t'(SyncLineEnd);
  localparam cnt_t VLastC = cnt_t'(TotalLines - 1);

  cnt_t hcnt_q, hcnt_d;
  cnt_t vcnt_q, vcnt_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic de_q, de_d;

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == HLast) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VLastC) ? '0 : vcnt_q + 10'd1;
    end

    hs_d = ~in_span(hcnt_q, HSyncStart, HSyncEnd);
    vs_d = ~in_span(vcnt_q, VSyncB, VSyncE);
    de_d = (hcnt_q < HVisible) && (vcnt_q < VVisC);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      de_q   <= 1'b0;
    end else if (pix_ce_i) begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
    end
  end

  assign hcnt_o = hcnt_q;
  assign vcnt_o = vcnt_q;
  assign hs_o   = hs_q;
  assign vs_o   = vs_q;
  assign de_o   = de_q;

endmodule

// File: rtl/screen_scan.sv
// screen_scan: scans a 64x640 Z88 bitmap out of VRAM onto a 640x480 raster.
//
// Ports:
//   mck      master clock, all logic on its rising edge
//   rin      synchronous active-high reset
//   pix_ce   pixel enable; counters, fetch and outputs advance only when high
//   lcdon    0 blanks ink without disturbing timing
//   vram_a   VRAM address {zline[5:0], nib[7:0]}
//   vram_di  VRAM nibble, bit 3 = leftmost pixel, valid one mck after vram_a
//   hs, vs   active-low syncs
//   de       visible-area enable
//   pix      pixel out, 1 = ink
//
// Build option: define SCREEN_SCAN_BORDER_EN to draw solid lines on the display
// lines just above and just below the Z88 window (independent of lcdon).
//
// Pipeline per nibble n (hcnt 4n..4n+3):
//   hcnt 4n-2  address of nibble n is driven (798 of the previous line for n=0)
//   hcnt 4n-1  vram_di captured into hold_q
//   hcnt 4n    hold_q enters the shifter; its MSB is pix for this column
// Vertical geometry parameters exist so reduced frames can be built; the defaults
// come from scan_pkg.
module screen_scan
  import scan_pkg::*;
#(
  parameter int unsigned VisLines    = VVisible,
  parameter int unsigned SyncLineBeg = VSyncStart,
  parameter int unsigned SyncLineEnd = VSyncEnd,
  parameter int unsigned TotalLines  = VTotal,
  parameter int unsigned WinTop      = WinStart,
  parameter int unsigned WinRows     = WinLines
) (
  input  logic             mck,
  input  logic             rin,
  input  logic             pix_ce,
  input  logic             lcdon,
  output logic [AddrW-1:0] vram_a,
  input  logic [3:0]       vram_di,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic             pix
);

  localparam cnt_t WinTopC = cnt_t'(WinTop);
  localparam cnt_t WinEndC = cnt_t'(WinTop + WinRows);
  localparam cnt_t VLastC  = cnt_t'(TotalLines - 1);
`ifdef SCREEN_SCAN_BORDER_EN
  localparam cnt_t BorderTopC = cnt_t'(WinTop - 1);
`endif

  cnt_t hcnt;
  cnt_t vcnt;

  scan_timing #(
    .VisLines    (VisLines),
    .SyncLineBeg (SyncLineBeg),
    .SyncLineEnd (SyncLineEnd),
    .TotalLines  (TotalLines)
  ) u_timing (
    .clk_i    (mck),
    .rst_i    (rin),
    .pix_ce_i (pix_ce),
    .hcnt_o   (hcnt),
    .vcnt_o   (vcnt),
    .hs_o     (hs),
    .vs_o     (vs),
    .de_o     (de)
  );

  logic [AddrW-1:0] vram_a_q, vram_a_d;
  logic [3:0]       hold_q, hold_d;
  logic [3:0]       shift_q, shift_d;
  logic             pix_q, pix_d;

  // Fetch targets the column two pixels ahead, which may be on the next line.
  logic            line_end;
  cnt_t            fetch_v;
  logic [NibW-1:0] fetch_nib;
  logic            fetch_ok;

  always_comb begin
    line_end  = (hcnt == HFetchWrap);
    fetch_v   = vcnt;
    fetch_nib = 8'((hcnt + 10'd2) >> 2);
    if (line_end) begin
      fetch_v   = (vcnt == VLastC) ? '0 : vcnt + 10'd1;
      fetch_nib = '0;
    end
    fetch_ok = (hcnt[1:0] == 2'd2) && in_span(fetch_v, WinTopC, WinEndC)
               && (fetch_nib < NibsPerRow);

    // Outside the window and past nibble 159 the address simply holds.
    vram_a_d = vram_a_q;
    if (fetch_ok) begin
      vram_a_d = {ZLineW'((fetch_v - WinTopC) >> RepeatLog2), fetch_nib};
    end
  end

  logic       load;
  logic [3:0] cur;
  logic       in_win;

  always_comb begin
    hold_d = hold_q;
    if (hcnt[1:0] == 2'd3) begin
      hold_d = vram_di;
    end

    // On a nibble boundary the held nibble is loaded and its MSB used at once,
    // keeping pix on the same one-tick latency as de/hs/vs.
    load    = (hcnt[1:0] == 2'd0);
    cur     = load ? hold_q : shift_q;
    shift_d = {cur[2:0], 1'b0};

    in_win = in_span(vcnt, WinTopC, WinEndC);
    pix_d  = cur[3] & lcdon & in_win & (hcnt < HVisible);
`ifdef SCREEN_SCAN_BORDER_EN
    if (((vcnt == BorderTopC) || (vcnt == WinEndC)) && (hcnt < HVisible)) begin
      pix_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge mck) begin
    if (rin) begin
      vram_a_q <= '0;
      hold_q   <= '0;
      shift_q  <= '0;
      pix_q    <= 1'b0;
    end else if (pix_ce) begin
      vram_a_q <= vram_a_d;
      hold_q   <= hold_d;
      shift_q  <= shift_d;
      pix_q    <= pix_d;
    end
  end

  assign vram_a = vram_a_q;
  assign pix    = pix_q;

endmodule

// File: tb/tb_screen_scan.sv
// Directed bench for screen_scan on a shortened frame: 22 lines total, 16 visible,
// vsync on lines 18-19, Z88 window on lines 4..11 (two source lines of 4 repeats).
// Horizontal timing is the full 800-pixel line.
module tb_screen_scan;

  localparam int VIS = 16;
  localparam int SYB = 18;
  localparam int SYE = 20;
  localparam int TOT = 22;
  localparam int WT  = 4;
  localparam int WR  = 8;

`ifdef SCREEN_SCAN_BORDER_EN
  localparam logic BRD = 1'b1;
`else
  localparam logic BRD = 1'b0;
`endif

  logic        mck = 1'b0;
  logic        rin;
  logic        pix_ce;
  logic        lcdon;
  logic [13:0] vram_a;
  logic [3:0]  vram_di;
  logic        hs, vs, de, pix;

  always #5 mck = ~mck;

  logic [3:0] mem [16384];
  assign vram_di = mem[vram_a];

  screen_scan #(
    .VisLines    (VIS),
    .SyncLineBeg (SYB),
    .SyncLineEnd (SYE),
    .TotalLines  (TOT),
    .WinTop      (WT),
    .WinRows     (WR)
  ) dut (
    .mck     (mck),
    .rin     (rin),
    .pix_ce  (pix_ce),
    .lcdon   (lcdon),
    .vram_a  (vram_a),
    .vram_di (vram_di),
    .hs      (hs),
    .vs      (vs),
    .de      (de),
    .pix     (pix)
  );

  typedef struct {
    int          ph;
    int          v;
    int          h;
    logic        pix;
    logic        de;
    logic        hs;
    logic        vs;
    bit          cva;
    logic [13:0] va;
  } vec_t;

  vec_t tbl[$];
  int tests = 0;
  int fails = 0;
  int vi = 0;
  // Model counters (ch,cv) and the position the outputs currently show (oh,ov).
  int ch = 0, cv = 0, oh = 0, ov = 0;
  logic [17:0] snap;
  int freeze_err = 0, stalls = 0;
  int hs_line = 0, bad_lines = 0, hs_total = 0, vs_total = 0, nib_bad = 0;

  task automatic add(input int ph, input int v, input int h, input logic p, input logic d,
                     input logic hs_e, input logic vs_e, input bit cva = 1'b0,
                     input logic [13:0] va = '0);
    vec_t e;
    e.ph = ph; e.v = v; e.h = h; e.pix = p; e.de = d; e.hs = hs_e; e.vs = vs_e;
    e.cva = cva; e.va = va;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t e);
    string tag;
    tag = $sformatf("ph%0d(%0d,%0d)", e.ph, e.v, e.h);
    chk({tag, " pix"}, 32'(pix), 32'(e.pix));
    chk({tag, " de"},  32'(de),  32'(e.de));
    chk({tag, " hs"},  32'(hs),  32'(e.hs));
    chk({tag, " vs"},  32'(vs),  32'(e.vs));
    if (e.cva) chk({tag, " vram_a"}, 32'(vram_a), 32'(e.va));
  endtask

  task automatic step(input bit ce);
    @(negedge mck);
    pix_ce = ce;
    @(posedge mck);
    #1;
    if (rin) begin
      ch = 0;
      cv = 0;
    end else if (ce) begin
      oh = ch;
      ov = cv;
      if (ch == 799) begin
        ch = 0;
        cv = (cv == TOT - 1) ? 0 : cv + 1;
      end else begin
        ch++;
      end
    end
  endtask

  // Tick (one enable every div mck) until the outputs show (sv,sh), checking
  // table entries of phase ph as their positions come up.
  task automatic run(input int ph, input int div, input int sv, input int sh);
    int guard;
    guard = 0;
    forever begin
      if (ph == 2) begin
        if (cv == 6 && ch == 320) lcdon = 1'b0;
        if (cv == 8 && ch == 0) lcdon = 1'b1;
      end
      for (int k = 1; k < div; k++) begin
        step(1'b0);
        stalls++;
        if ({vram_a, hs, vs, de, pix} !== snap) freeze_err++;
      end
      step(1'b1);
      snap = {vram_a, hs, vs, de, pix};
      if (ph == 1) begin
        if (!hs) begin hs_line++; hs_total++; end
        if (!vs) vs_total++;
        if (vram_a[7:0] > 8'd159) nib_bad++;
        if (oh == 799) begin
          if (hs_line != 96) bad_lines++;
          hs_line = 0;
        end
      end
      while (vi < tbl.size() && tbl[vi].ph == ph && tbl[vi].v == ov && tbl[vi].h == oh) begin
        apply_vec(tbl[vi]);
        vi++;
      end
      guard++;
      if (ov == sv && oh == sh) break;
      if (guard >= 20000) begin
        tests++;
        fails++;
        $display("FAIL ph%0d run bound: at (%0d,%0d), required (%0d,%0d)", ph, ov, oh, sv, sh);
        break;
      end
    end
    while (vi < tbl.size() && tbl[vi].ph == ph) begin
      tests++;
      fails++;
      $display("FAIL ph%0d vector (%0d,%0d): reached 0, required 1", ph, tbl[vi].v, tbl[vi].h);
      vi++;
    end
  endtask

  initial begin
    // Phase 1: pix_ce every mck, VRAM {0,0}=A and {1,159}=F.
    add(1, 0, 0,     0,   1, 1, 1);
    add(1, 3, 0,     BRD, 1, 1, 1);
    add(1, 3, 639,   BRD, 1, 1, 1);
    add(1, 3, 640,   0,   0, 1, 1);
    add(1, 4, 0,     1,   1, 1, 1);
    add(1, 4, 1,     0,   1, 1, 1);
    add(1, 4, 2,     1,   1, 1, 1, 1'b1, 14'd1);
    add(1, 4, 3,     0,   1, 1, 1);
    add(1, 4, 4,     0,   1, 1, 1);
    add(1, 4, 636,   0,   1, 1, 1);
    add(1, 5, 655,   0,   0, 1, 1);
    add(1, 5, 656,   0,   0, 0, 1);
    add(1, 5, 751,   0,   0, 0, 1);
    add(1, 5, 752,   0,   0, 1, 1);
    add(1, 7, 0,     1,   1, 1, 1);
    add(1, 7, 2,     1,   1, 1, 1);
    add(1, 7, 634,   0,   1, 1, 1, 1'b1, 14'd159);
    add(1, 7, 638,   0,   1, 1, 1, 1'b1, 14'd159);
    add(1, 8, 0,     0,   1, 1, 1);
    add(1, 8, 2,     0,   1, 1, 1, 1'b1, 14'd257);
    add(1, 8, 636,   1,   1, 1, 1);
    add(1, 8, 639,   1,   1, 1, 1);
    add(1, 8, 640,   0,   0, 1, 1);
    add(1, 11, 637,  1,   1, 1, 1);
    add(1, 12, 0,    BRD, 1, 1, 1, 1'b1, 14'd415);
    add(1, 13, 636,  0,   1, 1, 1);
    add(1, 15, 639,  0,   1, 1, 1);
    add(1, 16, 0,    0,   0, 1, 1);
    add(1, 17, 799,  0,   0, 1, 1);
    add(1, 18, 0,    0,   0, 1, 0);
    add(1, 19, 799,  0,   0, 1, 0);
    add(1, 20, 0,    0,   0, 1, 1);
    // Phase 2: pix_ce every 4th mck, all-ink VRAM, lcdon low on line 6 from 320 to line 8.
    add(2, 4, 0,     1,   1, 1, 1);
    add(2, 6, 319,   1,   1, 1, 1);
    add(2, 6, 320,   0,   1, 1, 1);
    add(2, 6, 639,   0,   1, 1, 1);
    add(2, 6, 640,   0,   0, 1, 1);
    add(2, 6, 656,   0,   0, 0, 1);
    add(2, 7, 100,   0,   1, 1, 1);
    add(2, 8, 0,     1,   1, 1, 1);
    // Phase 3: after a mid-line reset, VRAM {0,0}=A.
    add(3, 0, 0,     0,   1, 1, 1, 1'b1, 14'd0);
    add(3, 0, 656,   0,   0, 0, 1);
    add(3, 3, 798,   0,   0, 1, 1, 1'b1, 14'd0);
    add(3, 4, 0,     1,   1, 1, 1);
    add(3, 4, 1,     0,   1, 1, 1);
    add(3, 4, 2,     1,   1, 1, 1, 1'b1, 14'd1);
    add(3, 4, 6,     0,   1, 1, 1, 1'b1, 14'd2);

    for (int i = 0; i < 16384; i++) mem[i] = 4'h0;
    mem[0]   = 4'hA;
    mem[415] = 4'hF;

    rin    = 1'b1;
    pix_ce = 1'b0;
    lcdon  = 1'b1;
    repeat (3) step(1'b1);
    chk("reset vram_a", 32'(vram_a), 32'd0);
    chk("reset pix",    32'(pix),    32'd0);
    chk("reset de",     32'(de),     32'd0);
    chk("reset hs",     32'(hs),     32'd1);
    chk("reset vs",     32'(vs),     32'd1);
    rin  = 1'b0;
    snap = {vram_a, hs, vs, de, pix};

    run(1, 1, TOT - 1, 799);
    chk("lines with hs low count != 96", 32'(bad_lines), 32'd0);
    chk("hs low ticks per frame",        32'(hs_total),  32'(96 * TOT));
    chk("vs low ticks per frame",        32'(vs_total),  32'(2 * 800));
    chk("vram_a nib above 159",          32'(nib_bad),   32'd0);

    for (int i = 0; i < 16384; i++) mem[i] = 4'hF;
    run(8, 1, 3, 799);
    run(2, 4, 8, 0);
    chk("outputs moved while pix_ce low", 32'(freeze_err), 32'd0);
    chk("lcdon restored", 32'(lcdon), 32'd1);

    run(9, 1, 9, 399);
    rin = 1'b1;
    for (int i = 0; i < 16384; i++) mem[i] = 4'h0;
    mem[0] = 4'hA;
    step(1'b1);
    step(1'b1);
    chk("mid reset vram_a", 32'(vram_a), 32'd0);
    chk("mid reset pix",    32'(pix),    32'd0);
    chk("mid reset de",     32'(de),     32'd0);
    chk("mid reset hs",     32'(hs),     32'd1);
    chk("mid reset vs",     32'(vs),     32'd1);
    rin = 1'b0;
    run(3, 1, 4, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
